// File: rtl/crack_pkg.sv
// rtl/crack_pkg.sv - shared key width, key type and scheduler state encoding
// Contents:
//   KEY_W         : ARC4 key width in bits (24)
//   key_t         : one key value
//   sched_state_t : scheduler states IDLE, LAUNCH, RUN, ABORT
package crack_pkg;

  localparam int KEY_W = 24;

  typedef logic [KEY_W-1:0] key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    ABORT  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/crack_sched_lowest_hit_sel.sv
// rtl/crack_sched_lowest_hit_sel.sv - lowest-index select of a reported key among hitting cores
// Ports:
//   hit_vec [N]       : per-core hit qualifier (done & found & pending)
//   keys    [N*KEY_W] : per-core reported key, core i in bits [i*KEY_W +: KEY_W]
//   hit               : at least one core hit this cycle
//   sel_key           : key of the lowest-index hitting core, 0 when no hit
module lowest_hit_sel
  import crack_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]       hit_vec,
  input  logic [N*KEY_W-1:0] keys,
  output logic               hit,
  output key_t               sel_key
);

  always_comb begin
    hit     = |hit_vec;
    sel_key = '0;
    // Walk from the top down so the lowest set index is the last writer.
    for (int i = N - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_key = keys[i*KEY_W +: KEY_W];
      end
    end
  end

endmodule

// File: rtl/crack_sched.sv
// rtl/crack_sched.sv - multi-core ARC4 key-search scheduler
// Optional feature macro: CRACK_SCHED_ABORT_EN (first found key aborts the remaining cores)
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   en / rdy              : start request / scheduler idle and accepting a start
//   key / key_valid       : recovered key and its qualifier, held until the next start
//   core_en [N]           : one-cycle launch pulse to every core
//   core_base [N*24]      : start key of core i (= i)
//   core_stride [24]      : common key increment (= NUM_CORES)
//   core_rdy [N]          : core i idle
//   core_done [N]         : core i finished (found, exhausted or aborted)
//   core_found [N]        : core i found a key, qualified by core_done[i]
//   core_key [N*24]       : key from core i, qualified by core_done[i] & core_found[i]
//   core_abort [N]        : level request for core i to stop early
module crack_sched
  import crack_pkg::*;
#(
  parameter int NUM_CORES = 2,   // 1..8
  parameter int KEY_W     = crack_pkg::KEY_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  output logic                       rdy,
  output logic [KEY_W-1:0]           key,
  output logic                       key_valid,
  output logic [NUM_CORES-1:0]       core_en,
  output logic [NUM_CORES*KEY_W-1:0] core_base,
  output logic [KEY_W-1:0]           core_stride,
  input  logic [NUM_CORES-1:0]       core_rdy,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_found,
  input  logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic [NUM_CORES-1:0]       core_abort
);

  sched_state_t         state, state_nxt;
  logic [NUM_CORES-1:0] pending;
  logic [NUM_CORES-1:0] pending_left;
  logic [NUM_CORES-1:0] hit_vec;
  logic                 launch_go;
  logic                 hit_any;
  logic                 take_hit;
  key_t                 hit_key;

  // Interleaved partition: core i tries i, i+N, i+2N, ...
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_base
    assign core_base[i*KEY_W +: KEY_W] = KEY_W'(i);
  end
  assign core_stride = KEY_W'(NUM_CORES);

  assign launch_go    = (state == LAUNCH) && (&core_rdy);
  // Done pulses from cores that are no longer pending fall out here.
  assign pending_left = pending & ~core_done;
  assign hit_vec      = core_done & core_found & pending;
  // Only the first hit of a run is kept; later finds are discarded.
  assign take_hit     = (state == RUN) && hit_any && !key_valid;

  lowest_hit_sel #(
    .N (NUM_CORES)
  ) u_sel (
    .hit_vec (hit_vec),
    .keys    (core_key),
    .hit     (hit_any),
    .sel_key (hit_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rdy        = 1'b0;
    core_en    = '0;
    core_abort = '0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        // All cores start together, so wait until every core is idle.
        if (launch_go) begin
          core_en   = '1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (pending_left == '0) begin
          state_nxt = IDLE;
        end
`ifdef CRACK_SCHED_ABORT_EN
        else if (take_hit) begin
          state_nxt = ABORT;
        end
`endif
      end
      ABORT: begin
`ifdef CRACK_SCHED_ABORT_EN
        core_abort = pending;
        if (pending_left == '0) begin
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      key       <= '0;
      key_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            key       <= '0;
            key_valid <= 1'b0;
          end
        end
        LAUNCH: begin
          if (launch_go) begin
            pending <= '1;
          end
        end
        RUN: begin
          pending <= pending_left;
          if (take_hit) begin
            key       <= hit_key;
            key_valid <= 1'b1;
          end
        end
        ABORT: begin
          // Aborted cores may still report a find; it is not kept.
          pending <= pending_left;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crack_sched.sv
// tb/tb_crack_sched.sv - scoreboard bench for crack_sched with emulated crack cores
module tb_crack_sched;

  localparam int NC = 2;
  localparam int KW = 24;
  localparam logic [NC-1:0] ALL1 = '1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              rdy;
  logic [KW-1:0]     key;
  logic              key_valid;
  logic [NC-1:0]     core_en;
  logic [NC*KW-1:0]  core_base;
  logic [KW-1:0]     core_stride;
  logic [NC-1:0]     core_rdy = '1;
  logic [NC-1:0]     core_done = '0;
  logic [NC-1:0]     core_found = '0;
  logic [NC*KW-1:0]  core_key = '0;
  logic [NC-1:0]     core_abort;

  int checks = 0;
  int errors = 0;

  logic [KW:0] sb_q[$];
  logic [KW:0] mon_exp;
  logic        prev_rdy = 1'b1;

  crack_sched #(
    .NUM_CORES (NC),
    .KEY_W     (KW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .rdy         (rdy),
    .key         (key),
    .key_valid   (key_valid),
    .core_en     (core_en),
    .core_base   (core_base),
    .core_stride (core_stride),
    .core_rdy    (core_rdy),
    .core_done   (core_done),
    .core_found  (core_found),
    .core_key    (core_key),
    .core_abort  (core_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every return to idle presents one run result.
  always @(negedge clk) begin
    if (rdy === 1'b1 && prev_rdy !== 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: result key %0h valid %0b with no expected entry", key, key_valid);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("result_key_valid", 64'(key_valid), 64'(mon_exp[KW]));
        chk("result_key", 64'(key), 64'(mon_exp[KW-1:0]));
      end
    end
    prev_rdy = rdy;
  end

  // Start a run and bring it to the launch pulse; returns at the first negedge after launch.
  task automatic start_run(input int stall);
    logic [NC*KW-1:0] exp_base;
    chk("rdy_idle", 64'(rdy), 64'd1);
    en = 1'b1;
    core_rdy = '1;
    if (stall > 0) core_rdy[NC-1] = 1'b0;
    @(negedge clk);
    en = 1'b0;
    chk("rdy_after_en", 64'(rdy), 64'd0);
    chk("key_valid_cleared", 64'(key_valid), 64'd0);
    chk("key_cleared", 64'(key), 64'd0);
    for (int s = 0; s < stall; s++) begin
      chk("core_en_stalled", 64'(core_en), 64'd0);
      @(negedge clk);
    end
    core_rdy = '1;
    #1;
    for (int i = 0; i < NC; i++) exp_base[i*KW +: KW] = KW'(i);
    chk("core_en_pulse", 64'(core_en), 64'(ALL1));
    chk("core_base", 64'(core_base), 64'(exp_base));
    chk("core_stride", 64'(core_stride), 64'(NC));
    @(negedge clk);
    chk("core_en_one_cycle", 64'(core_en), 64'd0);
  endtask

  task automatic run_case(input int dly[NC], input bit fnd[NC], input logic [KW-1:0] kk[NC],
                          input int stall);
    int          term[NC];
    bit          fe[NC];
    bit          done_f[NC];
    int          best;
    int          h;
    int          lat;
    bit          all_done;
    logic [KW:0] expv;
    logic [NC-1:0] am;

    // Reference: the earliest find wins, lowest index on equal times.
    best = -1;
    for (int i = 0; i < NC; i++) begin
      if (fnd[i] && (best < 0 || dly[i] < dly[best])) best = i;
    end
    expv = (best < 0) ? '0 : {1'b1, kk[best]};
    h    = (best < 0) ? -1 : dly[best];
    am   = '0;
    for (int i = 0; i < NC; i++) am[i] = (h > 0) && (dly[i] > h);
    lat  = int'($urandom_range(1, 3));
    for (int i = 0; i < NC; i++) begin
      term[i]   = dly[i];
      fe[i]     = fnd[i];
      done_f[i] = 1'b0;
    end
    sb_q.push_back(expv);

    start_run(stall);
    all_done = 1'b0;
    for (int k = 1; k <= 40 && !all_done; k++) begin
      if (h > 0 && k == h + 1) begin
        chk("key_valid_after_hit", 64'(key_valid), 64'd1);
        chk("key_after_hit", 64'(key), 64'(kk[best]));
`ifdef CRACK_SCHED_ABORT_EN
        chk("core_abort_mask", 64'(core_abort), 64'(am));
`endif
      end
`ifndef CRACK_SCHED_ABORT_EN
      if (k == 1) chk("core_abort_off", 64'(core_abort), 64'd0);
`else
      for (int i = 0; i < NC; i++) begin
        if (core_abort[i] === 1'b1 && !done_f[i] && term[i] > k + lat) begin
          term[i] = k + lat;
          fe[i]   = 1'b0;
        end
      end
`endif
      core_done = '0;
      all_done  = 1'b1;
      for (int i = 0; i < NC; i++) begin
        core_found[i] = 1'($urandom);
        core_key[i*KW +: KW] = KW'($urandom);
        if (!done_f[i] && term[i] == k) begin
          core_done[i]  = 1'b1;
          core_found[i] = fe[i];
          if (fe[i]) core_key[i*KW +: KW] = kk[i];
          done_f[i] = 1'b1;
        end
        if (!done_f[i]) all_done = 1'b0;
      end
      if (all_done) chk("rdy_busy_at_last_done", 64'(rdy), 64'd0);
      @(negedge clk);
    end
    core_done  = '0;
    core_found = '0;
    if (!all_done) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: cores not all done within budget");
    end
    chk("rdy_after_last_done", 64'(rdy), 64'd1);
    chk("core_abort_idle", 64'(core_abort), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d[NC];
    bit          f[NC];
    logic [KW-1:0] kk[NC];

    repeat (2) @(negedge clk);
    chk("reset_rdy", 64'(rdy), 64'd1);
    chk("reset_key", 64'(key), 64'd0);
    chk("reset_key_valid", 64'(key_valid), 64'd0);
    chk("reset_core_en", 64'(core_en), 64'd0);
    chk("reset_core_abort", 64'(core_abort), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Core 1 finds early, core 0 exhausts five cycles later.
    d = '{6, 1}; f = '{1'b0, 1'b1}; kk = '{24'h0, 24'h000A3F};
    run_case(d, f, kk, 0);
    // Neither core finds.
    d = '{3, 4}; f = '{1'b0, 1'b0}; kk = '{24'h123456, 24'h654321};
    run_case(d, f, kk, 0);
    // Simultaneous finds: lowest index kept.
    d = '{2, 2}; f = '{1'b1, 1'b1}; kk = '{24'h000010, 24'h000011};
    run_case(d, f, kk, 0);
    // Launch held off by a busy core.
    d = '{2, 5}; f = '{1'b1, 1'b0}; kk = '{24'hABCDEF, 24'h0};
    run_case(d, f, kk, 3);

    // Reset in the middle of a run with a key already latched.
    sb_q.push_back('0);
    start_run(0);
    core_done = 2'b01; core_found = 2'b01; core_key = {24'h0, 24'h00BEEF};
    @(negedge clk);
    core_done = '0; core_found = '0;
    @(negedge clk);
    chk("key_valid_before_reset", 64'(key_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_rdy", 64'(rdy), 64'd1);
    chk("midrun_reset_key_valid", 64'(key_valid), 64'd0);
    chk("midrun_reset_core_abort", 64'(core_abort), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    d = '{4, 7}; f = '{1'b0, 1'b1}; kk = '{24'h0, 24'h77AA55};
    run_case(d, f, kk, 1);

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NC; i++) begin
        d[i]  = int'($urandom_range(1, 12));
        f[i]  = 1'($urandom);
        kk[i] = KW'($urandom);
      end
      run_case(d, f, kk, int'($urandom_range(0, 2)));
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crack_sched.md
# crack_sched

Multi-core key-search scheduler for the ARC4 cracking datapath. It accepts one start request on the standard `en`/`rdy` handshake and partitions the 24-bit key space across `NUM_CORES` crack engines with interleaved bases and a common stride. It launches all engines together, collects their results and reports a single `key`/`key_valid`. It sits between the top-level control and the array of crack cores.

## Interface
Parameters:
- `NUM_CORES`, 2: number of crack engines; legal range 1..8.
- `KEY_W`, 24: key width; fixed to the package constant.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  start request; sampled only when `rdy`=1.
- `rdy`  out  1  scheduler idle and accepting a start.
- `key`  out  24  recovered key.
- `key_valid`  out  1  `key` holds a found key.
- `core_en`  out  NUM_CORES  one-cycle start pulse to each core.
- `core_base`  out  NUM_CORES*24  start key for core i; equals i. Stable whenever `rdy`=0.
- `core_stride`  out  24  key increment for every core; equals NUM_CORES.
- `core_rdy`  in  NUM_CORES  core i idle.
- `core_done`  in  NUM_CORES  one-cycle pulse when core i ends (found, exhausted or aborted).
- `core_found`  in  NUM_CORES  core i found a key; qualified by `core_done[i]`.
- `core_key`  in  NUM_CORES*24  key from core i; qualified by `core_done[i] & core_found[i]`.
- `core_abort`  out  NUM_CORES  level request for core i to terminate early.

## Operation
- States: `IDLE`, `LAUNCH`, `RUN`, `ABORT`.
- Reset values:
  - State is `IDLE`.
  - `rdy`=1, `key`=0, `key_valid`=0.
  - `core_en`=0, `core_abort`=0.
  - Pending mask is 0.
- `IDLE`:
  - `rdy`=1.
  - `en`=1 clears `key`/`key_valid` and moves to `LAUNCH`.
- `LAUNCH`:
  - `core_en` = all ones when `&core_rdy`; otherwise all zeros.
  - In the cycle `core_en` is asserted: load pending mask to all ones and move to `RUN`.
- `RUN`, for each core with `core_done[i]` and pending bit i set:
  - Clear pending bit i.
  - If `core_found[i]` and `key_valid`=0: latch `core_key[i]` and set `key_valid`.
  - Simultaneous finds in one cycle: the lowest index wins; the other finds are discarded.
- Leaving `RUN`:
  - Pending mask reaches 0 → `IDLE`.
  - First hit with `CRACK_SCHED_ABORT_EN` defined → `ABORT`.
- `ABORT`:
  - `core_abort[i]` = pending bit i.
  - Each `core_done` clears its pending bit; `core_found` is ignored.
  - Pending mask 0 → `IDLE`, `core_abort` = 0.
- Ignored inputs:
  - `core_done` while the pending bit is clear, or outside `RUN`/`ABORT`.
  - `en` while `rdy`=0.
- `key`/`key_valid` hold from the end of a run until the next accepted `en`.
- Reset asserted mid-run: immediate return to reset values. Cores share `rst_n` and reset themselves.

## Timing
- `en` sampled high with `rdy`=1 at edge T: `rdy`=0 and `key_valid`=0 from T+1.
- `core_en` is a decode of the registered state and `core_rdy`. Earliest assertion is the cycle after T, and it lasts exactly one cycle.
- `core_done` with a find at edge F: `key`/`key_valid` updated from F+1.
- Last pending `core_done` at edge D: `rdy`=1 from D+1; the next start is accepted at D+1.
- With the abort feature: `core_abort` is high from F+1 until the cycle after that core's `core_done`.
- No combinational path from `en` to any output.

## Configuration
- `CRACK_SCHED_ABORT_EN` defined:
  - The first found key aborts all still-pending cores.
  - Completion time becomes first hit plus abort latency.
- Undefined:
  - The `ABORT` state is not built and `core_abort` is tied to 0.
  - The scheduler waits for every core to finish; the first hit by time (lowest index on ties) is kept.

## Structure
- Shared package `crack_pkg`:
  - `KEY_W`=24.
  - `typedef logic [KEY_W-1:0] key_t`.
  - `sched_state_t` enum (`IDLE`, `LAUNCH`, `RUN`, `ABORT`).
- One sub-module, `lowest_hit_sel`: combinational lowest-index select over `core_done & core_found & pending`. Outputs a hit flag and the selected `key_t`.

## Test plan
- Reset, then `NUM_CORES`=2, all `core_rdy`=1, `en` pulse → `core_en`=2'b11 for exactly 1 cycle; `core_base`={1,0}; `core_stride`=2; `rdy`=0.
- Core 1 reports done+found with key 24'h00_0A3F; core 0 reports exhausted 5 cycles later → `key`=24'h00_0A3F and `key_valid`=1. With the macro, `core_abort`=2'b01 until core 0 done. `rdy`=1 the cycle after the last done.
- Both cores report done, not found → `key_valid`=0, `key`=0, `rdy`=1.
- Both cores report found in the same cycle (keys 24'h000010, 24'h000011) → `key`=24'h000010.
- `core_rdy`=2'b01 at launch → `core_en` stays 0 until `core_rdy`=2'b11, then pulses once.
- `rst_n` low during `RUN` → `rdy`=1, `key_valid`=0 and `core_abort`=0 immediately. A fresh `en` afterwards runs normally.
